// File: rtl/tone_scheduler_if.sv
// Tone scheduler bus: divider inputs, key/autoplay controls and speaker-side outputs.
interface tone_scheduler_if #(
    parameter int unsigned SEQ_LEN = 8
);
    localparam int unsigned StepW = $clog2(SEQ_LEN);

    logic [3:0]           tone_in;
    logic [3:0]           key_req;
    logic                 play_start;
    logic                 play_stop;
    logic [3*SEQ_LEN-1:0] seq_pattern;
    logic                 speaker_out;
    logic [1:0]           note_sel;
    logic                 note_active;
    logic                 busy;
    logic [StepW-1:0]     step_idx;

    // Driver side (board / bench)
    modport master (
        output tone_in, key_req, play_start, play_stop, seq_pattern,
        input  speaker_out, note_sel, note_active, busy, step_idx
    );

    // Scheduler side
    modport slave (
        input  tone_in, key_req, play_start, play_stop, seq_pattern,
        output speaker_out, note_sel, note_active, busy, step_idx
    );
endinterface

// File: rtl/tone_scheduler.sv
// Speaker pin arbiter: manual note keys versus a timed autoplay sequencer
// stepping through a pattern latched at start. All outputs are registered.
module tone_scheduler #(
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SEQ_LEN     = 8
) (
    input  logic             clk_50MHz,
    input  logic             reset_button,
    tone_scheduler_if.slave  bus
);
    localparam int unsigned MaxCycles = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned StepW     = $clog2(SEQ_LEN);

    localparam logic [TimerW-1:0] NoteLast = TimerW'(NOTE_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);
    localparam logic [StepW-1:0]  StepLast = StepW'(SEQ_LEN - 1);

    typedef enum logic [1:0] {StIdle, StManual, StNote, StGap} state_e;

    state_e               r_state;
    logic [TimerW-1:0]    r_timer;
    logic [StepW-1:0]     r_step;
    logic [3*SEQ_LEN-1:0] r_pattern;
    logic [1:0]           r_note_sel;
    logic                 r_note_active;
    logic                 r_busy;
    logic                 r_speaker;

    logic                 w_start;
    logic                 w_playing;
    logic [2:0]           w_steps [SEQ_LEN];
    logic [StepW-1:0]     w_step_next;
    logic [2:0]           w_next_entry;
    logic [2:0]           w_first_entry;
    logic [1:0]           w_key_low;
    logic                 w_key_held;
    logic                 w_tone;

    // A simultaneous stop cancels a start everywhere
    assign w_start       = bus.play_start & ~bus.play_stop;
    assign w_playing     = (r_state == StNote) || (r_state == StGap);
    assign w_step_next   = r_step + 1'b1;
    assign w_next_entry  = w_steps[w_step_next];
    assign w_first_entry = bus.seq_pattern[2:0];
    assign w_key_held    = bus.key_req[r_note_sel];
    assign w_tone        = bus.tone_in[r_note_sel];

    for (genvar k = 0; k < SEQ_LEN; k++) begin : g_steps
        assign w_steps[k] = r_pattern[3*k +: 3];
    end

    // Lowest set key wins the grant
    always_comb begin
        w_key_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.key_req[i]) begin
                w_key_low = 2'(i);
            end
        end
    end

    // Scheduler FSM with its registered outputs and the speaker retiming flop
    always_ff @(posedge clk_50MHz) begin
        if (reset_button) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_step        <= '0;
            r_pattern     <= '0;
            r_note_sel    <= 2'd0;
            r_note_active <= 1'b0;
            r_busy        <= 1'b0;
            r_speaker     <= 1'b0;
        end else begin
            r_speaker <= r_note_active & w_tone;

            if (!w_playing && w_start) begin
                // Autoplay beats manual keys from both IDLE and MANUAL
                r_state       <= StNote;
                r_timer       <= '0;
                r_step        <= '0;
                r_pattern     <= bus.seq_pattern;
                r_note_sel    <= w_first_entry[1:0];
                r_note_active <= ~w_first_entry[2];
                r_busy        <= 1'b1;
            end else if (w_playing && bus.play_stop) begin
                r_state       <= StIdle;
                r_timer       <= '0;
                r_step        <= '0;
                r_note_active <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.key_req != 4'd0) begin
                            r_state       <= StManual;
                            r_note_sel    <= w_key_low;
                            r_note_active <= 1'b1;
                        end
                    end
                    StManual: begin
                        // Release always passes through IDLE before re-arbitration
                        if (!w_key_held) begin
                            r_state       <= StIdle;
                            r_note_active <= 1'b0;
                        end
                    end
                    StNote: begin
                        if (r_timer == NoteLast) begin
                            r_state       <= StGap;
                            r_timer       <= '0;
                            r_note_active <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    StGap: begin
                        if (r_timer == GapLast) begin
                            r_timer <= '0;
                            if (r_step == StepLast) begin
                                // step_idx stays on the last step; no wrap
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state       <= StNote;
                                r_step        <= w_step_next;
                                r_note_sel    <= w_next_entry[1:0];
                                r_note_active <= ~w_next_entry[2];
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.speaker_out = r_speaker;
    assign bus.note_sel    = r_note_sel;
    assign bus.note_active = r_note_active;
    assign bus.busy        = r_busy;
    assign bus.step_idx    = r_step;
endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench for tone_scheduler: a cycle-level reference model built on
// elapsed playback time pushes expected outputs; a negedge monitor compares.
module tb_tone_scheduler;
    localparam int unsigned NoteCyc = 10;
    localparam int unsigned GapCyc  = 4;
    localparam int unsigned SeqLen  = 4;
    localparam int unsigned StepW   = $clog2(SeqLen);
    localparam int unsigned Period  = NoteCyc + GapCyc;

    typedef struct packed {
        logic             spk;
        logic [1:0]       sel;
        logic             act;
        logic             busy;
        logic [StepW-1:0] step;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    // Reference model state: 0 idle, 1 manual, 2 playing
    int                  m_mode;
    int                  m_t;
    logic [3*SeqLen-1:0] m_pat;
    exp_t                m_out;

    tone_scheduler_if #(.SEQ_LEN(SeqLen)) bus_if ();

    tone_scheduler #(
        .NOTE_CYCLES (NoteCyc),
        .GAP_CYCLES  (GapCyc),
        .SEQ_LEN     (SeqLen)
    ) dut (
        .clk_50MHz    (clk),
        .reset_button (rst),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Expected outputs after the coming edge, from the current inputs
    task automatic model_step();
        exp_t nxt;
        logic [2:0] e;
        int k;
        int w;
        bit start;
        int lo;
        nxt = m_out;
        if (rst) begin
            nxt    = '0;
            m_mode = 0;
            m_t    = 0;
            m_pat  = '0;
        end else begin
            nxt.spk = m_out.act & bus_if.tone_in[m_out.sel];
            start   = bus_if.play_start && !bus_if.play_stop;
            if (m_mode != 2 && start) begin
                m_mode   = 2;
                m_t      = 0;
                m_pat    = bus_if.seq_pattern;
                nxt.step = '0;
                nxt.busy = 1'b1;
                nxt.sel  = m_pat[1:0];
                nxt.act  = !m_pat[2];
            end else if (m_mode == 0) begin
                if (bus_if.key_req != 4'd0) begin
                    lo = -1;
                    for (int i = 0; i < 4; i++) begin
                        if (lo < 0 && bus_if.key_req[i]) lo = i;
                    end
                    m_mode  = 1;
                    nxt.sel = 2'(lo);
                    nxt.act = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (!bus_if.key_req[m_out.sel]) begin
                    m_mode  = 0;
                    nxt.act = 1'b0;
                end
            end else if (bus_if.play_stop) begin
                m_mode   = 0;
                nxt.step = '0;
                nxt.busy = 1'b0;
                nxt.act  = 1'b0;
            end else begin
                m_t++;
                if (m_t == int'(SeqLen * Period)) begin
                    m_mode   = 0;
                    nxt.busy = 1'b0;
                    nxt.act  = 1'b0;
                end else begin
                    k        = m_t / Period;
                    w        = m_t % Period;
                    e        = m_pat[3*k +: 3];
                    nxt.step = StepW'(k);
                    if (w < int'(NoteCyc)) begin
                        nxt.sel = e[1:0];
                        nxt.act = !e[2];
                    end else begin
                        nxt.act = 1'b0;
                    end
                end
            end
        end
        m_out = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic tick();
        bus_if.tone_in = 4'($urandom);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus_if.play_start = 1'b1;
        tick();
        bus_if.play_start = 1'b0;
    endtask

    // Monitor: compares the DUT against each queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("speaker_out", 32'(bus_if.speaker_out), 32'(e.spk));
            check("note_sel",    32'(bus_if.note_sel),    32'(e.sel));
            check("note_active", 32'(bus_if.note_active), 32'(e.act));
            check("busy",        32'(bus_if.busy),        32'(e.busy));
            check("step_idx",    32'(bus_if.step_idx),    32'(e.step));
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_mode  = 0;
        m_t     = 0;
        m_pat   = '0;
        m_out   = '0;
        rst                = 1'b1;
        bus_if.tone_in     = 4'd0;
        bus_if.key_req     = 4'd0;
        bus_if.play_start  = 1'b0;
        bus_if.play_stop   = 1'b0;
        bus_if.seq_pattern = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Manual arbitration and release through one idle cycle
        bus_if.key_req = 4'b0110;
        repeat (6) tick();
        bus_if.key_req = 4'b0100;
        repeat (6) tick();
        bus_if.key_req = 4'b0000;
        repeat (3) tick();

        // Full playback with a rest on step 2
        bus_if.seq_pattern = 12'b011_100_001_000;
        pulse_start();
        repeat (60) tick();

        // Stop at playback cycle 15, then start+stop together in idle
        pulse_start();
        repeat (14) tick();
        bus_if.play_stop = 1'b1;
        tick();
        bus_if.play_stop = 1'b0;
        repeat (3) tick();
        bus_if.play_start = 1'b1;
        bus_if.play_stop  = 1'b1;
        tick();
        bus_if.play_start = 1'b0;
        bus_if.play_stop  = 1'b0;
        repeat (3) tick();

        // Key held across playback, takes over afterwards
        bus_if.key_req = 4'b1000;
        pulse_start();
        repeat (62) tick();
        bus_if.key_req = 4'b0000;
        repeat (3) tick();

        // Pattern scrambled during playback
        bus_if.seq_pattern = 12'($urandom);
        pulse_start();
        repeat (60) begin
            bus_if.seq_pattern = 12'($urandom);
            tick();
        end

        // Reset mid-note
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Random soak
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) bus_if.key_req = 4'($urandom);
            bus_if.play_start  = ($urandom_range(0, 99) < 3);
            bus_if.play_stop   = ($urandom_range(0, 99) < 2);
            bus_if.seq_pattern = 12'($urandom);
            rst                = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst               = 1'b0;
        bus_if.play_start = 1'b0;
        bus_if.play_stop  = 1'b0;
        tick();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
